trace_sequencer: RTL

Controller between the address-trace reader and the direct-mapped data cache. On `start` it pulls one 15-bit address at a time from the reader, presents it to the cache with a request/ready handshake, and tallies accesses, hits and misses. It stops after the address flagged as last by the reader, or on a cache-response timeout. It is the top-level driver of trace-based cache simulation runs.

---
 rtl/cache_sim_pkg.sv | 18 +
 rtl/sat_counter.sv | 35 +++
 rtl/trace_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: shared definitions for the trace-driven cache simulation.
//   DEF_ADDR_W  - default address width (matches the trace reader data width)
//   DEF_CNT_W   - default width of the statistics counters
//   seq_state_t - trace_sequencer FSM states
package cache_sim_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk   - clock
//   rst   - synchronous active-high clear
//   inc   - add one this cycle (ignored once saturated)
//   count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: drives a cache from an address-trace reader.
// Each access walks FETCH (pulse reader_en) -> LOAD (capture address and
// end-of-trace flag) -> ISSUE (hold cache_req until cache_ready or timeout).
// Stops in DONE after the last address or a timeout; only rst leaves DONE.
//   clk, rst                         - clock, synchronous active-high reset
//   start                            - one-cycle run request (IDLE only)
//   reader_en / reader_data /
//   reader_finish                    - trace reader handshake
//   cache_req / cache_addr /
//   cache_ready / cache_hit          - cache access handshake
//   access_count/hit_count/miss_count- saturating statistics
//   busy, done, timeout_err          - run status
import cache_sim_pkg::*;

module trace_sequencer #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              reader_en,
    input  logic [ADDR_W-1:0] reader_data,
    input  logic              reader_finish,
    output logic              cache_req,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_ready,
    input  logic              cache_hit,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    // Wait counter counts ISSUE cycles without cache_ready: 0 .. TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              complete;

    // cache_ready is only meaningful while a request is outstanding.
    assign complete = (state_q == ST_ISSUE) && cache_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                addr_d  = reader_data;
                last_d  = reader_finish;
                wait_d  = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A completion in the timeout cycle wins over the timeout.
                if (cache_ready) begin
                    state_d = last_q ? ST_DONE : ST_FETCH;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_access_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (complete),
        .count (access_count)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (complete && cache_hit),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (complete && !cache_hit),
        .count (miss_count)
    );

    assign reader_en   = (state_q == ST_FETCH);
    assign cache_req   = (state_q == ST_ISSUE);
    assign cache_addr  = addr_q;
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                         (state_q == ST_ISSUE);
    assign done        = (state_q == ST_DONE);
    assign timeout_err = err_q;

endmodule
